sigan_gate_ctrl: RTL and testbench

Gate/window controller for the 16-bit signature analyzer datapath (`sigan`). It synchronizes the asynchronous probe clock, start, stop and data lines into the system clock domain and detects the user-selected edges. It runs the ARMED/OPEN/CLOSE window sequence and issues clear/shift strobes to the datapath. It latches the resulting signature and flags instability between successive windows, HP 5004 style.

---
 rtl/sigan_pkg.sv | 21 ++
 rtl/sigan_sync_edge.sv | 30 +++
 rtl/sigan_gate_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_sigan_gate_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sigan_pkg.sv
// Shared types and constants for the sigan gate/window controller.
package sigan_pkg;

    localparam int unsigned SIG_W = 16;

    localparam logic EDGE_RISE = 1'b1;
    localparam logic EDGE_FALL = 1'b0;

    typedef enum logic [1:0] {
        ARMED = 2'd0,
        OPEN  = 2'd1,
        CLOSE = 2'd2,
        DONE  = 2'd3
    } sigan_state_e;

    // True when prev->cur is a transition in the direction chosen by sel.
    function automatic logic edge_match(input logic prev, input logic cur, input logic sel);
        return (prev != cur) && (cur == (sel == EDGE_RISE));
    endfunction

endpackage

// File: rtl/sigan_sync_edge.sv
// N-stage synchronizer for one asynchronous line with one-cycle rise/fall event pulses.
module sigan_sync_edge
    import sigan_pkg::*;
#(
    parameter int unsigned STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic in_i,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              last_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            last_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], in_i};
            last_q <= sync_q[STAGES-1];
        end
    end

    assign rise_o = sync_q[STAGES-1] & ~last_q;
    assign fall_o = ~sync_q[STAGES-1] & last_q;

endmodule

// File: rtl/sigan_gate_ctrl.sv
// Gate/window controller for the sigan signature datapath.
// Optional probe-clock timeout is built when SIGAN_TIMEOUT_EN is defined.
module sigan_gate_ctrl
    import sigan_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             probe_clock,
    input  logic             probe_start,
    input  logic             probe_stop,
    input  logic             probe_data,
    input  logic             clk_edge,
    input  logic             start_edge,
    input  logic             stop_edge,
    input  logic             hold,
    input  logic             rearm,
    input  logic [SIG_W-1:0] sig_value,
    output logic             sig_clear,
    output logic             sig_shift,
    output logic             sig_data,
    output logic [SIG_W-1:0] signature,
    output logic             valid,
    output logic             unstable,
    output logic             gate,
    output logic [CNT_W-1:0] window_len,
    output logic             overflow,
    output logic             no_clock
);

    localparam int unsigned LW = 3 * SYNC_STAGES;

    sigan_state_e state_q, state_d;

    logic             clk_rise, clk_fall, probe_ev;
    logic [LW-1:0]    line_sync_q;
    logic             line_start, line_stop, line_data;
    logic             start_smp_q, stop_smp_q;
    logic             start_ev, stop_ev, timeout;
    logic [2:0]       sel_q, sel_d, sel;
    logic [CNT_W-1:0] cnt_q, cnt_d, len_q, len_d;
    logic             cnt_ovf_q, cnt_ovf_d, ovf_q, ovf_d;
    logic             clear_q, clear_d, shift_q, shift_d, data_q, data_d;
    logic             gate_q, gate_d, valid_q, valid_d, unstable_q, unstable_d;
    logic             prev_valid_q, prev_valid_d;
    logic [SIG_W-1:0] sig_q, sig_d;

    sigan_sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_clk_sync (
        .clock  (clock),
        .reset  (reset),
        .in_i   (probe_clock),
        .rise_o (clk_rise),
        .fall_o (clk_fall)
    );

    // Start, stop and data share one shift chain, three bits per stage.
    assign {line_start, line_stop, line_data} = line_sync_q[LW-1 -: 3];

    // Edge selects follow the inputs while ARMED and freeze for the window.
    assign sel      = (state_q == ARMED) ? {clk_edge, start_edge, stop_edge} : sel_q;
    assign sel_d    = sel;
    assign probe_ev = (sel[2] == EDGE_FALL) ? clk_fall : clk_rise;
    assign start_ev = probe_ev && edge_match(start_smp_q, line_start, sel[1]);
    assign stop_ev  = probe_ev && edge_match(stop_smp_q, line_stop, sel[0]);

`ifdef SIGAN_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            no_clock_q, no_clock_d;
    logic            watching;

    always_comb begin
        watching   = (state_q == ARMED) || (state_q == OPEN);
        timeout    = watching && !probe_ev && (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));
        to_cnt_d   = (probe_ev || timeout || !watching) ? '0 : to_cnt_q + 1'b1;
        no_clock_d = no_clock_q;
        if (probe_ev) begin
            no_clock_d = 1'b0;
        end else if (timeout) begin
            no_clock_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            to_cnt_q   <= '0;
            no_clock_q <= 1'b0;
        end else begin
            to_cnt_q   <= to_cnt_d;
            no_clock_q <= no_clock_d;
        end
    end

    assign no_clock = no_clock_q;
`else
    assign timeout  = 1'b0;
    assign no_clock = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        gate_d       = gate_q;
        clear_d      = 1'b0;
        shift_d      = 1'b0;
        data_d       = data_q;
        cnt_d        = cnt_q;
        cnt_ovf_d    = cnt_ovf_q;
        sig_d        = sig_q;
        valid_d      = valid_q;
        unstable_d   = unstable_q;
        len_d        = len_q;
        ovf_d        = ovf_q;
        prev_valid_d = prev_valid_q;

        unique case (state_q)
            ARMED: begin
                // A coincident stop event is dropped: start wins.
                if (start_ev) begin
                    clear_d   = 1'b1;
                    cnt_d     = '0;
                    cnt_ovf_d = 1'b0;
                    gate_d    = 1'b1;
                    state_d   = OPEN;
                end
            end
            OPEN: begin
                if (stop_ev) begin
                    gate_d  = 1'b0;
                    state_d = CLOSE;
                end else if (probe_ev) begin
                    shift_d = 1'b1;
                    data_d  = line_data;
                    if (cnt_q == {CNT_W{1'b1}}) begin
                        cnt_ovf_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            CLOSE: begin
                sig_d        = sig_value;
                len_d        = cnt_q;
                ovf_d        = cnt_ovf_q;
                valid_d      = 1'b1;
                unstable_d   = prev_valid_q && (sig_value != sig_q);
                prev_valid_d = 1'b1;
                state_d      = hold ? DONE : ARMED;
            end
            DONE: begin
                if (rearm) begin
                    state_d = ARMED;
                end
            end
            default: state_d = ARMED;
        endcase

        if (timeout) begin
            gate_d  = 1'b0;
            clear_d = 1'b0;
            shift_d = 1'b0;
            state_d = ARMED;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ARMED;
            line_sync_q  <= '0;
            start_smp_q  <= 1'b0;
            stop_smp_q   <= 1'b0;
            sel_q        <= '0;
            cnt_q        <= '0;
            cnt_ovf_q    <= 1'b0;
            clear_q      <= 1'b0;
            shift_q      <= 1'b0;
            data_q       <= 1'b0;
            gate_q       <= 1'b0;
            sig_q        <= '0;
            valid_q      <= 1'b0;
            unstable_q   <= 1'b0;
            len_q        <= '0;
            ovf_q        <= 1'b0;
            prev_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            line_sync_q  <= {line_sync_q[LW-4:0], probe_start, probe_stop, probe_data};
            if (probe_ev) begin
                start_smp_q <= line_start;
                stop_smp_q  <= line_stop;
            end
            sel_q        <= sel_d;
            cnt_q        <= cnt_d;
            cnt_ovf_q    <= cnt_ovf_d;
            clear_q      <= clear_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            gate_q       <= gate_d;
            sig_q        <= sig_d;
            valid_q      <= valid_d;
            unstable_q   <= unstable_d;
            len_q        <= len_d;
            ovf_q        <= ovf_d;
            prev_valid_q <= prev_valid_d;
        end
    end

    assign sig_clear  = clear_q;
    assign sig_shift  = shift_q;
    assign sig_data   = data_q;
    assign signature  = sig_q;
    assign valid      = valid_q;
    assign unstable   = unstable_q;
    assign gate       = gate_q;
    assign window_len = len_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_sigan_gate_ctrl.sv
// Scoreboard bench for sigan_gate_ctrl; stimulus queues expected strobes/results, a monitor checks.
module tb_sigan_gate_ctrl;

    localparam int K_CLR = 0;
    localparam int K_SHF = 1;
    localparam int K_RES = 2;

    typedef struct {
        int          kind;
        logic        d;
        logic [15:0] sig;
        logic        valid;
        logic        unstable;
        logic [7:0]  len;
        logic        ovf;
        logic        noclk;
    } exp_t;

    logic        clk, rst_n;
    logic        probe_clock, p_start, p_stop, p_data;
    logic        clk_edge, start_edge, stop_edge, hold, rearm;
    logic [15:0] sig_value;
    logic        sig_clear, sig_shift, sig_data, valid, unstable, gate, overflow, no_clock;
    logic [15:0] signature;
    logic [7:0]  window_len;

    exp_t exp_q[$];
    exp_t it;
    int   total = 0;
    int   bad = 0;
    logic gate_prev = 1'b0;
    logic pend = 1'b0;

    // Expectation model state.
    logic        prev_valid_m = 1'b0;
    logic [15:0] last_sig_m = '0;
    logic        last_valid_m = 1'b0;
    logic        last_unst_m = 1'b0;
    logic [7:0]  last_len_m = '0;
    logic        last_ovf_m = 1'b0;

    sigan_gate_ctrl #(
        .SYNC_STAGES (2),
        .CNT_W       (8),
        .TIMEOUT_CYC (100)
    ) dut (
        .clock       (clk),
        .reset       (rst_n),
        .probe_clock (probe_clock),
        .probe_start (p_start),
        .probe_stop  (p_stop),
        .probe_data  (p_data),
        .clk_edge    (clk_edge),
        .start_edge  (start_edge),
        .stop_edge   (stop_edge),
        .hold        (hold),
        .rearm       (rearm),
        .sig_value   (sig_value),
        .sig_clear   (sig_clear),
        .sig_shift   (sig_shift),
        .sig_data    (sig_data),
        .signature   (signature),
        .valid       (valid),
        .unstable    (unstable),
        .gate        (gate),
        .window_len  (window_len),
        .overflow    (overflow),
        .no_clock    (no_clock)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // HP-style 16-bit signature register: taps 7, 9, 12, 16.
    function automatic logic [15:0] sig_step(input logic [15:0] s, input logic d);
        return {s[14:0], d ^ s[15] ^ s[11] ^ s[8] ^ s[6]};
    endfunction

    // Reference datapath driving sig_value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sig_value <= '0;
        else if (sig_clear) sig_value <= '0;
        else if (sig_shift) sig_value <= sig_step(sig_value, sig_data);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expectation per strobe and per closed window.
    always @(negedge clk) begin
        if (!rst_n) begin
            gate_prev = 1'b0;
            pend = 1'b0;
        end else begin
            if (pend) begin
                pend = 1'b0;
                if (exp_q.size() == 0) begin
                    chk("unexp_result", exp_q.size(), 1);
                end else begin
                    it = exp_q.pop_front();
                    chk("res_kind", it.kind, K_RES);
                    chk("res_signature", {16'd0, signature}, {16'd0, it.sig});
                    chk("res_valid", {31'd0, valid}, {31'd0, it.valid});
                    chk("res_unstable", {31'd0, unstable}, {31'd0, it.unstable});
                    chk("res_window_len", {24'd0, window_len}, {24'd0, it.len});
                    chk("res_overflow", {31'd0, overflow}, {31'd0, it.ovf});
                    chk("res_no_clock", {31'd0, no_clock}, {31'd0, it.noclk});
                end
            end
            if (gate_prev && !gate) pend = 1'b1;
            gate_prev = gate;
            if (sig_clear && sig_shift) chk("clear_shift_overlap", {31'd0, sig_shift}, 0);
            if (sig_clear) begin
                if (exp_q.size() == 0) chk("unexp_clear", {31'd0, sig_clear}, 0);
                else begin
                    it = exp_q.pop_front();
                    chk("clear_kind", it.kind, K_CLR);
                end
            end else if (sig_shift) begin
                if (exp_q.size() == 0) chk("unexp_shift", {31'd0, sig_shift}, 0);
                else begin
                    it = exp_q.pop_front();
                    chk("shift_kind", it.kind, K_SHF);
                    chk("shift_data", {31'd0, sig_data}, {31'd0, it.d});
                end
            end
        end
    end

    task automatic push_ev(input int kind, input logic d);
        exp_t e;
        e = '{kind: kind, d: d, sig: '0, valid: 1'b0, unstable: 1'b0, len: '0, ovf: 1'b0,
              noclk: 1'b0};
        exp_q.push_back(e);
    endtask

    task automatic push_result(input logic [15:0] s, input int nshift);
        exp_t e;
        e = '{kind: K_RES, d: 1'b0, sig: s, valid: 1'b1,
              unstable: prev_valid_m && (s != last_sig_m),
              len: (nshift > 255) ? 8'd255 : 8'(nshift), ovf: nshift > 255, noclk: 1'b0};
        exp_q.push_back(e);
        prev_valid_m = 1'b1;
        last_sig_m   = s;
        last_valid_m = 1'b1;
        last_unst_m  = e.unstable;
        last_len_m   = e.len;
        last_ovf_m   = e.ovf;
    endtask

    // One probe clock period: lines set in the low phase, event on the rising edge.
    task automatic probe_event(input logic st, input logic sp, input logic d);
        @(negedge clk);
        p_start = st;
        p_stop = sp;
        p_data = d;
        probe_clock = 1'b0;
        repeat (4) @(negedge clk);
        probe_clock = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Start/stop tied: n events high; first is the start, the rest shift, falling edge stops.
    task automatic window(input int n, input int flip);
        logic [15:0] s;
        logic d;
        s = '0;
        probe_event(1'b0, 1'b0, 1'b0);
        probe_event(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            d = (i == flip) ? 1'b0 : 1'b1;
            if (i == 0) push_ev(K_CLR, 1'b0);
            else begin
                push_ev(K_SHF, d);
                s = sig_step(s, d);
            end
            probe_event(1'b1, 1'b1, d);
        end
        push_result(s, n - 1);
        probe_event(1'b0, 1'b0, 1'b0);
        probe_event(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] s;
        rst_n = 1'b0;
        probe_clock = 1'b0;
        p_start = 1'b0;
        p_stop = 1'b0;
        p_data = 1'b0;
        clk_edge = 1'b1;
        start_edge = 1'b1;
        stop_edge = 1'b0;
        hold = 1'b0;
        rearm = 1'b0;
        repeat (3) @(negedge clk);
        chk("init_gate", {31'd0, gate}, 0);
        chk("init_valid", {31'd0, valid}, 0);
        chk("init_signature", {16'd0, signature}, 0);
        chk("init_no_clock", {31'd0, no_clock}, 0);
        rst_n = 1'b1;

        // Identical windows, then one data bit flipped.
        window(256, -1);
        window(256, -1);
        window(256, 100);

        // Start and stop events on the same probe event while ARMED.
        probe_event(1'b0, 1'b1, 1'b0);
        probe_event(1'b0, 1'b1, 1'b0);
        push_ev(K_CLR, 1'b0);
        probe_event(1'b1, 1'b0, 1'b1);
        chk("same_event_gate", {31'd0, gate}, 1);
        s = '0;
        push_ev(K_SHF, 1'b1); s = sig_step(s, 1'b1); probe_event(1'b1, 1'b0, 1'b1);
        push_ev(K_SHF, 1'b0); s = sig_step(s, 1'b0); probe_event(1'b1, 1'b0, 1'b0);
        push_ev(K_SHF, 1'b1); s = sig_step(s, 1'b1); probe_event(1'b1, 1'b1, 1'b1);
        push_result(s, 3);
        probe_event(1'b1, 1'b0, 1'b0);
        probe_event(1'b1, 1'b0, 1'b0);

        // Single shot: window closes into DONE, further starts ignored until rearm.
        hold = 1'b1;
        window(4, -1);
        probe_event(1'b1, 1'b1, 1'b1);
        probe_event(1'b1, 1'b1, 1'b1);
        chk("done_gate", {31'd0, gate}, 0);
        probe_event(1'b0, 1'b0, 1'b0);
        chk("done_signature", {16'd0, signature}, {16'd0, last_sig_m});
        hold = 1'b0;
        @(negedge clk) rearm = 1'b1;
        @(negedge clk) rearm = 1'b0;
        window(3, -1);

        // Counter saturation: 300 shifts.
        window(301, -1);

        // Asynchronous reset mid-window.
        probe_event(1'b0, 1'b0, 1'b0);
        probe_event(1'b0, 1'b0, 1'b0);
        push_ev(K_CLR, 1'b0);
        probe_event(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            push_ev(K_SHF, 1'b1);
            probe_event(1'b1, 1'b1, 1'b1);
        end
        #3 rst_n = 1'b0;
        #1;
        chk("rst_gate", {31'd0, gate}, 0);
        chk("rst_valid", {31'd0, valid}, 0);
        chk("rst_unstable", {31'd0, unstable}, 0);
        chk("rst_signature", {16'd0, signature}, 0);
        chk("rst_window_len", {24'd0, window_len}, 0);
        chk("rst_overflow", {31'd0, overflow}, 0);
        chk("rst_strobes", {29'd0, sig_clear, sig_shift, sig_data}, 0);
        chk("rst_no_clock", {31'd0, no_clock}, 0);
        prev_valid_m = 1'b0;
        last_sig_m = '0;
        last_valid_m = 1'b0;
        last_unst_m = 1'b0;
        last_len_m = '0;
        last_ovf_m = 1'b0;
        p_start = 1'b0;
        p_stop = 1'b0;
        p_data = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        window(5, -1);

`ifdef SIGAN_TIMEOUT_EN
        // Probe clock stops while OPEN: abort without touching the result.
        probe_event(1'b0, 1'b0, 1'b0);
        push_ev(K_CLR, 1'b0);
        probe_event(1'b1, 1'b1, 1'b1);
        push_ev(K_SHF, 1'b1);
        probe_event(1'b1, 1'b1, 1'b1);
        begin
            exp_t e;
            e = '{kind: K_RES, d: 1'b0, sig: last_sig_m, valid: last_valid_m,
                  unstable: last_unst_m, len: last_len_m, ovf: last_ovf_m, noclk: 1'b1};
            exp_q.push_back(e);
        end
        repeat (150) @(negedge clk);
        chk("timeout_no_clock", {31'd0, no_clock}, 1);
        chk("timeout_gate", {31'd0, gate}, 0);
        probe_event(1'b0, 1'b0, 1'b0);
        chk("timeout_cleared", {31'd0, no_clock}, 0);
`endif

        repeat (20) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
